smi_write_packer: RTL and testbench
===================================

Name: smi_write_packer

Overview:
SMI write-path counterpart of the SMI read controller. The RPi writes bytes over SMI to addresses write_900 (3'b001) and write_2400 (3'b010). This block synchronises the SMI write strobe into the i_sys_clk domain, packs bytes MSB-first into 32-bit words per channel, and pushes each completed word into the matching TX FIFO (0.9 GHz or 2.4 GHz). It also drives SMI flow control and reports sticky errors.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the strobe/address/data synchroniser (minimum 2).
WORD_BYTES, 4, bytes per FIFO word; the FIFO word width is 8*WORD_BYTES.

Ports:
i_sys_clk  input  1  FPGA system clock.
i_reset_n  input  1  Asynchronous, active-low reset.
i_smi_a  input  3  SMI address.
i_smi_swe_srw  input  1  SMI write strobe, active low.
i_smi_data_in  input  8  SMI write data byte.
o_smi_write_ready  output  1  High when both TX FIFOs are not full.
o_fifo_09_push  output  1  One-cycle push strobe to the 0.9 GHz TX FIFO.
o_fifo_09_push_data  output  32  Word pushed to the 0.9 GHz FIFO.
i_fifo_09_full  input  1  0.9 GHz TX FIFO full.
o_fifo_24_push  output  1  One-cycle push strobe to the 2.4 GHz TX FIFO.
o_fifo_24_push_data  output  32  Word pushed to the 2.4 GHz FIFO.
i_fifo_24_full  input  1  2.4 GHz TX FIFO full.
i_realign  input  1  Synchronous; discards partial words on both channels.
i_clear_errors  input  1  Synchronous; clears the sticky error flags.
o_overflow_09  output  1  Sticky: a 0.9 GHz word was dropped because the FIFO was full.
o_overflow_24  output  1  Sticky: a 2.4 GHz word was dropped because the FIFO was full.
o_address_error  output  1  Sticky: a write strobe arrived with an invalid address.

Behaviour:
- Reset (i_reset_n=0, asynchronous): all synchroniser flops are set to the idle value (strobe=1, others 0). Byte counters = 0. Shift registers = 0. Push strobes = 0. Push data = 0. All error flags = 0. o_smi_write_ready reads 0 while in reset.
- Synchroniser: i_smi_swe_srw, i_smi_a and i_smi_data_in each pass through SYNC_STAGES flops. A capture event is a 1->0 transition of the synchronised strobe; it is one cycle wide.
- SMI timing contract: the strobe low and high widths must each be >= SYNC_STAGES+1 sys clocks. Address and data must be stable for SYNC_STAGES clocks before the strobe falls and throughout the low phase.
- On a capture event, the synchronised address is decoded:
  - 3'b001: the byte goes to channel 09.
  - 3'b010: the byte goes to channel 24.
  - 3'b011: sets o_address_error; the byte is discarded.
  - Any read address (a[2]=1) or 3'b000: ignored silently.
- Per-channel packer: shift register sr <= {sr[23:0], byte}. byte_cnt counts 0..WORD_BYTES-1.
  - The first byte lands in bits [31:24], matching the MSB-first byte order of the read path.
  - On the byte that makes byte_cnt wrap from WORD_BYTES-1 to 0, the word is complete.
  - Complete word and FIFO not full: push_data = completed word and push = 1 for exactly one cycle, on the cycle after the capture event.
  - Complete word and FIFO full: the word is dropped, push stays 0, and the overflow flag is set sticky. The counter still wraps, so alignment is preserved.
- Latency: SMI strobe falling edge to push asserted = SYNC_STAGES+2 sys clocks (4 at the default).
- Channels are independent. Interleaving writes to 09 and 24 never corrupts either partial word.
- o_fifo_xx_push_data holds its value until the next push on that channel.
- o_smi_write_ready = !i_fifo_09_full && !i_fifo_24_full, registered once (1-cycle lag). The RPi must stop after ready falls; the FIFOs must provide at least 2 words of slack after full de-asserts.
- i_realign: both byte_cnt = 0; shift registers are left as they are. If realign coincides with a capture event, realign wins and the byte is discarded. Push strobes already scheduled still fire.
- i_clear_errors coinciding with a new error event: the error wins, so the flag stays 1.
- Reset mid-word: the partial word is lost and no push occurs.

Decomposition:
- Shared package (smi_pkg): SMI address constants (idle, write_900, write_2400, write_res2, read_*), byte/word widths.
- One sub-module, smi_byte_packer: shift register, byte counter, full check, push and overflow logic. It is instantiated twice, once per channel.
- The synchroniser and address decode live in the top level.

Test Plan:
1. Reset, then 4 writes to addr 001 with data 0x11, 0x22, 0x33, 0x44 -> single o_fifo_09_push; data 0x11223344 at 4 clocks after the 4th strobe falls; no push on 24.
2. Interleave: 09 gets 0xA1, 24 gets 0xB1, 09 gets 0xA2/0xA3/0xA4, 24 gets 0xB2/0xB3/0xB4 -> 09 pushes 0xA1A2A3A4 and 24 pushes 0xB1B2B3B4, each exactly once.
3. i_fifo_24_full=1 and 4 bytes to addr 010 -> no push and o_overflow_24=1. Then full=0 and 4 bytes 0x01..0x04 -> push 0x01020304 with flag still 1. Pulse i_clear_errors -> flag=0.
4. Write to addr 011 -> o_address_error=1 with no counter change. Write to addr 101 -> no effect.
5. 2 bytes to 09, pulse i_realign, then 4 bytes 0xDE, 0xAD, 0xBE, 0xEF -> push 0xDEADBEEF only.
6. Assert i_reset_n=0 asynchronously after 3 bytes to 09, release, then 4 bytes 0xC0..0xC3 -> push 0xC0C1C2C3. All outputs read 0 during reset.

Source files
------------

// File: rtl/smi_pkg.sv
// Shared SMI constants and write-address decode for the SMI write path.
package smi_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DEF_WORD_BYTES = 4;

    localparam logic [2:0] SMI_A_IDLE       = 3'b000;
    localparam logic [2:0] SMI_A_WRITE_900  = 3'b001;
    localparam logic [2:0] SMI_A_WRITE_2400 = 3'b010;
    localparam logic [2:0] SMI_A_WRITE_RES2 = 3'b011;
    localparam logic [2:0] SMI_A_READ_BASE  = 3'b100;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_CH09,
        DEC_CH24,
        DEC_ERR
    } smi_dec_e;

    // Read addresses (a[2]=1) and idle are ignored by the write path.
    function automatic smi_dec_e smi_decode(input logic [2:0] a);
        smi_dec_e d;
        d = DEC_NONE;
        if ((a & SMI_A_READ_BASE) == 3'b000) begin
            case (a)
                SMI_A_WRITE_900:  d = DEC_CH09;
                SMI_A_WRITE_2400: d = DEC_CH24;
                SMI_A_WRITE_RES2: d = DEC_ERR;
                default:          d = DEC_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/smi_write_packer_if.sv
// SMI write bus between the RPi side (master) and the write packer (slave).
interface smi_write_packer_if;
    logic [2:0] i_smi_a;
    logic       i_smi_swe_srw;
    logic [7:0] i_smi_data_in;
    logic       o_smi_write_ready;

    modport master (
        output i_smi_a,
        output i_smi_swe_srw,
        output i_smi_data_in,
        input  o_smi_write_ready
    );

    modport slave (
        input  i_smi_a,
        input  i_smi_swe_srw,
        input  i_smi_data_in,
        output o_smi_write_ready
    );
endinterface

// File: rtl/smi_byte_packer.sv
// Per-channel MSB-first byte packer with FIFO push and sticky overflow.
module smi_byte_packer
    import smi_pkg::*;
#(
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                         i_sys_clk,
    input  logic                         i_reset_n,
    input  logic                         wr,
    input  logic [BYTE_W-1:0]            wr_byte,
    input  logic                         realign,
    input  logic                         clear_errors,
    input  logic                         fifo_full,
    output logic                         push,
    output logic [BYTE_W*WORD_BYTES-1:0] push_data,
    output logic                         overflow
);

    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W  = (WORD_BYTES > 2) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

    logic [WORD_W-1:0] sr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] next_word;
    logic              complete;

    assign next_word = {sr[WORD_W-BYTE_W-1:0], wr_byte};
    assign complete  = wr && !realign && (byte_cnt == CNT_LAST);

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr        <= '0;
            byte_cnt  <= '0;
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            push <= 1'b0;
            if (realign) begin
                byte_cnt <= '0;
            end else if (wr) begin
                sr       <= next_word;
                byte_cnt <= complete ? '0 : byte_cnt + CNT_W'(1);
                if (complete && !fifo_full) begin
                    push      <= 1'b1;
                    push_data <= next_word;
                end
            end
        end
    end

    // A new drop beats a simultaneous clear so no overflow is ever lost.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow <= 1'b0;
        end else if (complete && fifo_full) begin
            overflow <= 1'b1;
        end else if (clear_errors) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/smi_write_packer.sv
// SMI write path: synchronises the write strobe, decodes the address and
// feeds one byte packer per TX FIFO channel.
module smi_write_packer
    import smi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WORD_BYTES  = DEF_WORD_BYTES
) (
    input  logic                         i_sys_clk,
    input  logic                         i_reset_n,
    smi_write_packer_if.slave            smi,
    output logic                         o_fifo_09_push,
    output logic [BYTE_W*WORD_BYTES-1:0] o_fifo_09_push_data,
    input  logic                         i_fifo_09_full,
    output logic                         o_fifo_24_push,
    output logic [BYTE_W*WORD_BYTES-1:0] o_fifo_24_push_data,
    input  logic                         i_fifo_24_full,
    input  logic                         i_realign,
    input  logic                         i_clear_errors,
    output logic                         o_overflow_09,
    output logic                         o_overflow_24,
    output logic                         o_address_error
);

    logic [SYNC_STAGES-1:0] swe_sync;
    logic [2:0]             a_sync [SYNC_STAGES];
    logic [BYTE_W-1:0]      d_sync [SYNC_STAGES];
    logic                   swe_prev;
    logic                   capture;
    smi_dec_e               dec;

    logic              wr09_q;
    logic              wr24_q;
    logic [BYTE_W-1:0] byte_q;
    logic              ready_q;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            swe_sync <= '1;
            swe_prev <= 1'b1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= '0;
                d_sync[i] <= '0;
            end
        end else begin
            swe_sync  <= {swe_sync[SYNC_STAGES-2:0], smi.i_smi_swe_srw};
            swe_prev  <= swe_sync[SYNC_STAGES-1];
            a_sync[0] <= smi.i_smi_a;
            d_sync[0] <= smi.i_smi_data_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                d_sync[i] <= d_sync[i-1];
            end
        end
    end

    assign capture = swe_prev && !swe_sync[SYNC_STAGES-1];
    assign dec     = smi_decode(a_sync[SYNC_STAGES-1]);

    // Decoded byte is registered once so push lands SYNC_STAGES+2 clocks
    // after the strobe edge; realign during capture drops the byte here.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr09_q  <= 1'b0;
            wr24_q  <= 1'b0;
            byte_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            wr09_q  <= capture && (dec == DEC_CH09) && !i_realign;
            wr24_q  <= capture && (dec == DEC_CH24) && !i_realign;
            byte_q  <= d_sync[SYNC_STAGES-1];
            ready_q <= !i_fifo_09_full && !i_fifo_24_full;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_address_error <= 1'b0;
        end else if (capture && (dec == DEC_ERR)) begin
            o_address_error <= 1'b1;
        end else if (i_clear_errors) begin
            o_address_error <= 1'b0;
        end
    end

    assign smi.o_smi_write_ready = ready_q;

    smi_byte_packer #(.WORD_BYTES(WORD_BYTES)) u_pack_09 (
        .i_sys_clk    (i_sys_clk),
        .i_reset_n    (i_reset_n),
        .wr           (wr09_q),
        .wr_byte      (byte_q),
        .realign      (i_realign),
        .clear_errors (i_clear_errors),
        .fifo_full    (i_fifo_09_full),
        .push         (o_fifo_09_push),
        .push_data    (o_fifo_09_push_data),
        .overflow     (o_overflow_09)
    );

    smi_byte_packer #(.WORD_BYTES(WORD_BYTES)) u_pack_24 (
        .i_sys_clk    (i_sys_clk),
        .i_reset_n    (i_reset_n),
        .wr           (wr24_q),
        .wr_byte      (byte_q),
        .realign      (i_realign),
        .clear_errors (i_clear_errors),
        .fifo_full    (i_fifo_24_full),
        .push         (o_fifo_24_push),
        .push_data    (o_fifo_24_push_data),
        .overflow     (o_overflow_24)
    );

endmodule

// File: tb/tb_smi_write_packer.sv
// Directed bench for smi_write_packer: packing, interleave, overflow,
// address errors, realign and asynchronous reset.
module tb_smi_write_packer;

    logic        clk;
    logic        rst_n;
    logic        full09, full24;
    logic        realign, clear_err;
    logic        push09, push24;
    logic [31:0] data09, data24;
    logic        ovf09, ovf24, addr_err;

    smi_write_packer_if smi_bus ();

    smi_write_packer #(.SYNC_STAGES(2), .WORD_BYTES(4)) dut (
        .i_sys_clk           (clk),
        .i_reset_n           (rst_n),
        .smi                 (smi_bus),
        .o_fifo_09_push      (push09),
        .o_fifo_09_push_data (data09),
        .i_fifo_09_full      (full09),
        .o_fifo_24_push      (push24),
        .o_fifo_24_push_data (data24),
        .i_fifo_24_full      (full24),
        .i_realign           (realign),
        .i_clear_errors      (clear_err),
        .o_overflow_09       (ovf09),
        .o_overflow_24       (ovf24),
        .o_address_error     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          n09 = 0, n24 = 0;
    logic [31:0] last09 = '0, last24 = '0;
    time         t_push09 = 0;
    time         t_fall = 0;
    int          base09, base24;

    always @(negedge clk) begin
        if (push09) begin
            n09++;
            last09   = data09;
            t_push09 = $time;
        end
        if (push24) begin
            n24++;
            last24 = data24;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Setup 3 clocks, strobe low 4 clocks, high 4 clocks; changes on negedge.
    task automatic smi_write(input logic [2:0] a, input logic [7:0] d);
        smi_bus.i_smi_a       = a;
        smi_bus.i_smi_data_in = d;
        repeat (3) @(negedge clk);
        smi_bus.i_smi_swe_srw = 1'b0;
        t_fall = $time;
        repeat (4) @(negedge clk);
        smi_bus.i_smi_swe_srw = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        full09 = 1'b0; full24 = 1'b0;
        realign = 1'b0; clear_err = 1'b0;
        smi_bus.i_smi_a = 3'b000;
        smi_bus.i_smi_swe_srw = 1'b1;
        smi_bus.i_smi_data_in = 8'h00;
        repeat (3) @(negedge clk);

        check("reset_push09", {31'd0, push09}, 32'd0);
        check("reset_push24", {31'd0, push24}, 32'd0);
        check("reset_data09", data09, 32'd0);
        check("reset_data24", data24, 32'd0);
        check("reset_flags", {29'd0, ovf09, ovf24, addr_err}, 32'd0);
        check("reset_ready", {31'd0, smi_bus.o_smi_write_ready}, 32'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", {31'd0, smi_bus.o_smi_write_ready}, 32'd1);

        // 1: single word on channel 09 plus latency
        smi_write(3'b001, 8'h11);
        smi_write(3'b001, 8'h22);
        smi_write(3'b001, 8'h33);
        check("t1_no_early_push", n09, 0);
        smi_write(3'b001, 8'h44);
        check("t1_push_count09", n09, 1);
        check("t1_data09", last09, 32'h11223344);
        check("t1_latency", 32'((t_push09 - t_fall) / 10), 32'd4);
        check("t1_push_count24", n24, 0);
        check("t1_push_low", {31'd0, push09}, 32'd0);

        // 2: interleaved channels
        base09 = n09; base24 = n24;
        smi_write(3'b001, 8'hA1);
        smi_write(3'b010, 8'hB1);
        smi_write(3'b001, 8'hA2);
        smi_write(3'b001, 8'hA3);
        smi_write(3'b001, 8'hA4);
        smi_write(3'b010, 8'hB2);
        smi_write(3'b010, 8'hB3);
        smi_write(3'b010, 8'hB4);
        check("t2_count09", n09 - base09, 1);
        check("t2_count24", n24 - base24, 1);
        check("t2_data09", last09, 32'hA1A2A3A4);
        check("t2_data24", last24, 32'hB1B2B3B4);

        // 3: overflow on 24, recovery, clear
        full24 = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_ready_low", {31'd0, smi_bus.o_smi_write_ready}, 32'd0);
        base24 = n24;
        smi_write(3'b010, 8'h05);
        smi_write(3'b010, 8'h06);
        smi_write(3'b010, 8'h07);
        smi_write(3'b010, 8'h08);
        check("t3_no_push24", n24 - base24, 0);
        check("t3_ovf24_set", {31'd0, ovf24}, 32'd1);
        check("t3_ovf09_clear", {31'd0, ovf09}, 32'd0);
        full24 = 1'b0;
        repeat (2) @(negedge clk);
        smi_write(3'b010, 8'h01);
        smi_write(3'b010, 8'h02);
        smi_write(3'b010, 8'h03);
        smi_write(3'b010, 8'h04);
        check("t3_push24", n24 - base24, 1);
        check("t3_data24", last24, 32'h01020304);
        check("t3_ovf24_sticky", {31'd0, ovf24}, 32'd1);
        pulse_clear();
        check("t3_ovf24_cleared", {31'd0, ovf24}, 32'd0);

        // 4: address error, ignored read address, alignment intact
        base09 = n09; base24 = n24;
        smi_write(3'b011, 8'h99);
        check("t4_addr_err", {31'd0, addr_err}, 32'd1);
        smi_write(3'b101, 8'h77);
        check("t4_no_push", (n09 - base09) + (n24 - base24), 0);
        smi_write(3'b001, 8'h10);
        smi_write(3'b001, 8'h20);
        smi_write(3'b001, 8'h30);
        smi_write(3'b001, 8'h40);
        check("t4_count09", n09 - base09, 1);
        check("t4_data09", last09, 32'h10203040);
        pulse_clear();
        check("t4_addr_err_cleared", {31'd0, addr_err}, 32'd0);

        // 5: realign discards a partial word
        base09 = n09;
        smi_write(3'b001, 8'h55);
        smi_write(3'b001, 8'h66);
        realign = 1'b1;
        @(negedge clk);
        realign = 1'b0;
        @(negedge clk);
        smi_write(3'b001, 8'hDE);
        smi_write(3'b001, 8'hAD);
        smi_write(3'b001, 8'hBE);
        smi_write(3'b001, 8'hEF);
        check("t5_count09", n09 - base09, 1);
        check("t5_data09", last09, 32'hDEADBEEF);

        // 6: asynchronous reset mid-word
        smi_write(3'b011, 8'h00);
        base09 = n09;
        smi_write(3'b001, 8'h01);
        smi_write(3'b001, 8'h02);
        smi_write(3'b001, 8'h03);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data09", data09, 32'd0);
        check("t6_rst_data24", data24, 32'd0);
        check("t6_rst_flags", {29'd0, ovf09, ovf24, addr_err}, 32'd0);
        check("t6_rst_ready", {31'd0, smi_bus.o_smi_write_ready}, 32'd0);
        check("t6_rst_push", {30'd0, push09, push24}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_partial_push", n09 - base09, 0);
        smi_write(3'b001, 8'hC0);
        smi_write(3'b001, 8'hC1);
        smi_write(3'b001, 8'hC2);
        smi_write(3'b001, 8'hC3);
        check("t6_count09", n09 - base09, 1);
        check("t6_data09", last09, 32'hC0C1C2C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
